// File: rtl/axis_multibit_adder.sv
// axis_multibit_adder
//   Joins two WIDTH-bit AXI-Stream operand streams and produces, per accepted
//   operand pair, a WIDTH-bit sum (or difference) and a 1-bit carry (or
//   borrow). Each result goes into its own OUT_DEPTH-entry FIFO and drains
//   through an independent output stream.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   s_a_tvalid/tdata/tready    operand A stream
//   s_b_tvalid/tdata/tready    operand B stream
//   m_sum_tvalid/tdata/tready  sum (difference) result stream
//   m_carry_tvalid/tdata/tready carry (borrow) result stream
//   op_count                   accepted operand pairs, wraps modulo 2^16
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both high. tvalid never depends on tready; tdata is held stable while
// tvalid is high and tready is low. The two operand readies are one signal:
// a pair moves only when both operands are valid and both FIFOs have room.

// Result FIFO: circular buffer with an explicit occupancy count so that a
// full buffer can be told apart from an empty one without a spare entry.
module axis_multibit_adder_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          tready,
    output logic          full,
    output logic          tvalid,
    output logic [DW-1:0] tdata
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          pop;

    assign tvalid = (count != '0);
    assign full   = (count == FULL_COUNT);
    assign pop    = tvalid & tready;
    assign tdata  = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // Storage is cleared so the head reads as zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module axis_multibit_adder #(
    parameter int WIDTH     = 8,
    parameter int OUT_DEPTH = 4,
    parameter int SUB       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_a_tvalid,
    input  logic [WIDTH-1:0] s_a_tdata,
    output logic             s_a_tready,
    input  logic             s_b_tvalid,
    input  logic [WIDTH-1:0] s_b_tdata,
    output logic             s_b_tready,
    output logic             m_sum_tvalid,
    output logic [WIDTH-1:0] m_sum_tdata,
    input  logic             m_sum_tready,
    output logic             m_carry_tvalid,
    output logic [0:0]       m_carry_tdata,
    input  logic             m_carry_tready,
    output logic [15:0]      op_count
);
    logic             sum_full;
    logic             carry_full;
    logic             push;
    logic [WIDTH:0]   result;

    // Fullness is judged on registered occupancy only; a pop in the same
    // cycle does not free a slot until the following edge.
    assign push       = s_a_tvalid & s_b_tvalid & ~sum_full & ~carry_full & ~reset;
    assign s_a_tready = push;
    assign s_b_tready = push;

    // One extra bit holds carry-out for add; for subtract the same bit is
    // the sign of the (WIDTH+1)-bit difference, i.e. the borrow (a < b).
    always_comb begin
        result = '0;
        if (SUB != 0) begin
            result = {1'b0, s_a_tdata} - {1'b0, s_b_tdata};
        end else begin
            result = {1'b0, s_a_tdata} + {1'b0, s_b_tdata};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_count <= '0;
        end else if (push) begin
            op_count <= op_count + 16'd1;
        end
    end

    axis_multibit_adder_fifo #(
        .DW    (WIDTH),
        .DEPTH (OUT_DEPTH)
    ) u_sum_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .din    (result[WIDTH-1:0]),
        .tready (m_sum_tready),
        .full   (sum_full),
        .tvalid (m_sum_tvalid),
        .tdata  (m_sum_tdata)
    );

    axis_multibit_adder_fifo #(
        .DW    (1),
        .DEPTH (OUT_DEPTH)
    ) u_carry_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .din    (result[WIDTH:WIDTH]),
        .tready (m_carry_tready),
        .full   (carry_full),
        .tvalid (m_carry_tvalid),
        .tdata  (m_carry_tdata)
    );
endmodule

// File: doc/axis_multibit_adder.md
# axis_multibit_adder

Parametrised AXI-Stream adder/subtractor, successor to the single-bit stream half adder. It joins two WIDTH-bit operand streams and computes a sum (or difference) and a carry (or borrow) per operand pair. The sum and carry each go to an independent output stream, buffered in its own FIFO of depth OUT_DEPTH, so the two consumers may drain at different rates while the block sustains one operation per cycle. It sits between operand producers and separate sum/carry consumers in the arithmetic datapath.

## Interface
- WIDTH, 8: operand and sum width in bits, 1..32.
- OUT_DEPTH, 4: entries in each output FIFO; power of two, 2..16.
- SUB, 0: 0 selects add (sum = a+b, carry = carry-out); 1 selects subtract (sum = a−b, carry = borrow).
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_a_tvalid  in  1  operand A valid.
- s_a_tdata  in  WIDTH  operand A.
- s_a_tready  out  1  operand A accepted.
- s_b_tvalid  in  1  operand B valid.
- s_b_tdata  in  WIDTH  operand B.
- s_b_tready  out  1  operand B accepted.
- m_sum_tvalid  out  1  sum FIFO non-empty.
- m_sum_tdata  out  WIDTH  head of sum FIFO.
- m_sum_tready  in  1  sum consumer ready.
- m_carry_tvalid  out  1  carry FIFO non-empty.
- m_carry_tdata  out  1  head of carry FIFO.
- m_carry_tready  in  1  carry consumer ready.
- op_count  out  16  number of accepted operand pairs; wraps modulo 2^16.

## Operation
- Join rule: a pair is accepted ("push") in a cycle when s_a_tvalid=1, s_b_tvalid=1, sum FIFO not full and carry FIFO not full.
- s_a_tready = s_b_tready = push. Both readies are driven from the same signal and are never asserted individually. A lone valid operand is held by its producer and is never consumed alone.
- The full test uses the current occupancy only. A full FIFO that is popped in the same cycle does not admit a push in that cycle.
- Arithmetic with SUB=0: r = a + b computed at WIDTH+1 bits. sum = r[WIDTH-1:0]; carry = r[WIDTH].
- Arithmetic with SUB=1: sum = (a − b) mod 2^WIDTH; carry = 1 exactly when a < b (unsigned).
- On push, sum is written into the sum FIFO and carry into the carry FIFO in the same cycle.
- Each FIFO is a circular buffer with write pointer, read pointer and an occupancy count of 0..OUT_DEPTH. Pointers wrap from OUT_DEPTH−1 to 0.
- Pop on the sum side = m_sum_tvalid & m_sum_tready. Pop on the carry side = m_carry_tvalid & m_carry_tready. The two pops are independent.
- Simultaneous push and pop on the same FIFO leaves the count unchanged and moves both pointers.
- m_*_tvalid = (count != 0).
- m_*_tdata = storage[read pointer]. The value is stable while valid is high and ready is low.
- op_count increments by 1 on each push.

## Timing
- Reset values: m_sum_tvalid=0, m_carry_tvalid=0, m_sum_tdata=0, m_carry_tdata=0, op_count=0, FIFO counts 0, all pointers 0. s_a_tready and s_b_tready are 0 while reset=1.
- Reset mid-operation flushes both FIFOs on the next edge. Pending results are discarded and no partial output is produced.
- Latency: a push at edge T produces m_*_tvalid=1 with the result in the cycle after T.
- Throughput: one operand pair per cycle while both FIFOs have space.
- Readies are combinational from tvalid and the registered counts. tvalid never depends on tready.
- Once a FIFO holds OUT_DEPTH entries, readies stay low until that FIFO's count drops below OUT_DEPTH. The release happens on the edge following a pop.
- After a pop the next entry appears in the following cycle. m_*_tvalid stays high with no bubble while entries remain.

## Test plan
- WIDTH=8, SUB=0, both consumers always ready. Inputs 0x0F+0x01, 0xFF+0x01, 0x80+0x80 -> sum/carry of 0x10/0, 0x00/1, 0x00/1 on consecutive cycles, one cycle after each push. op_count=3.
- WIDTH=8, SUB=1. Inputs 0x05−0x03, 0x03−0x05, 0x00−0x00 -> 0x02/0, 0xFE/1, 0x00/0.
- Only A valid (0x11) for 5 cycles -> s_a_tready stays 0 and nothing is produced. B then asserts 0x22 -> a single push, sum 0x33/0.
- OUT_DEPTH=4, m_carry_tready=0, m_sum_tready=1. Push 6 pairs back-to-back -> exactly 4 accepted and readies drop. The sum stream drains 4 values while carry holds the first value stable. Raising m_carry_tready then drains the carries in order and readies reassert to accept the remaining 2 pairs.
- Both FIFOs full. Pop and offered push in the same cycle -> the push is rejected in that cycle and accepted in the next cycle. No entry is lost or duplicated, and order is preserved.
- Assert reset for 1 cycle with 3 entries queued and an operand pair offered -> on the next cycle both tvalids=0, tdata=0, op_count=0, and no push occurs during reset.
